// File: rtl/mipi_pkt_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mipi_pkt_pkg: constants and state type shared by MIPI TX and RX   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package mipi_pkt_pkg;

   localparam int          c_WORD_W         = 48;
   localparam logic [23:0] c_SOF_DEFAULT    = 24'hEAFF99;
   localparam logic [7:0]  c_DTYPE_DEFAULT  = 8'h01;
   localparam logic [7:0]  c_PHL_ID_DEFAULT = 8'h00;
   localparam int          c_MIN_GAP        = 17;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SOF   = 3'd1,
      ST_HDR   = 3'd2,
      ST_DATA  = 3'd3,
      ST_TRAIL = 3'd4,
      ST_GAP   = 3'd5
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/mipi_word_shifter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mipi_word_shifter: payload load / shift-left-by-one-word register |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module mipi_word_shifter
   import mipi_pkt_pkg::*;
#(
   parameter int DLEN  = 6,
   parameter int CNT_W = 1
)(
   input  logic                  tx_pixel_clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [DLEN*8-1:0]     load_data,
   input  logic                  shift,
   output logic [c_WORD_W-1:0]   word,
   output logic [CNT_W-1:0]      word_count
);

   logic [DLEN*8-1:0] r_shreg;
   logic [CNT_W-1:0]  r_count;

   // Payload storage needs no reset: it is always loaded before it is read.
   always_ff @(posedge tx_pixel_clk) begin
      if (load) begin
         r_shreg <= load_data;
      end else if (shift) begin
         r_shreg <= r_shreg << c_WORD_W;
      end
   end

   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= '0;
      end else if (shift) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign word       = r_shreg[DLEN*8-1 -: c_WORD_W];
   assign word_count = r_count;

endmodule
`default_nettype wire

// File: rtl/mipi_packet_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mipi_packet_tx: frames one payload as SOF/header/data/trailer     |
// | pixel words followed by an idle gap. Revision: 1.0                |
// +------------------------------------------------------------------+
module mipi_packet_tx
   import mipi_pkt_pkg::*;
#(
   parameter int          DLEN   = 6,
   parameter logic [23:0] SOF    = c_SOF_DEFAULT,
   parameter logic [7:0]  DTYPE  = c_DTYPE_DEFAULT,
   parameter logic [7:0]  PHL_ID = c_PHL_ID_DEFAULT,
   parameter int          GAP    = c_MIN_GAP
)(
   input  logic                  tx_pixel_clk,
   input  logic                  rst_n,
   input  logic [DLEN*8-1:0]     data,
   input  logic                  data_valid,
   output logic                  data_ready,
   output logic [c_WORD_W-1:0]   packet,
   output logic                  my_mipi_tx_VALID,
   output logic [23:0]           pkt_count
);

   localparam int c_NW     = DLEN / 6;
   localparam int c_CNT_W  = $clog2(c_NW + 1);
   localparam int c_GAP_W  = $clog2(GAP);
   localparam int c_HALF_W = c_WORD_W / 2;

   if (DLEN % 6 != 0 || DLEN <= 0 || DLEN > 6 * 65536) begin : g_bad_dlen
      $error("mipi_packet_tx: DLEN must be a positive multiple of 6 and at most 6*2^16");
   end
   if (GAP < c_MIN_GAP) begin : g_bad_gap
      $error("mipi_packet_tx: GAP must be at least 17");
   end

   tx_state_t            r_state;
   tx_state_t            w_next_state;
   logic [c_GAP_W-1:0]   r_gap_cnt;
   logic [23:0]          r_pkt_count;
   logic [c_WORD_W-1:0]  r_packet;
   logic [c_WORD_W-1:0]  w_packet;
   logic                 r_valid;
   logic                 w_valid;
   logic                 r_ready;
   logic                 w_ready;
   logic                 w_handshake;
   logic                 w_shift;
   logic [c_WORD_W-1:0]  w_word;
   logic [c_CNT_W-1:0]   w_word_count;

   assign w_handshake = data_valid && r_ready;

   mipi_word_shifter #(
      .DLEN  (DLEN),
      .CNT_W (c_CNT_W)
   ) u_shifter (
      .tx_pixel_clk (tx_pixel_clk),
      .rst_n        (rst_n),
      .load         (w_handshake),
      .load_data    (data),
      .shift        (w_shift),
      .word         (w_word),
      .word_count   (w_word_count)
   );

   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_handshake) w_next_state = ST_SOF;
         ST_SOF:   w_next_state = ST_HDR;
         ST_HDR:   w_next_state = ST_DATA;
         ST_DATA:  if (w_word_count == c_CNT_W'(c_NW)) w_next_state = ST_TRAIL;
         ST_TRAIL: w_next_state = ST_GAP;
         ST_GAP:   if (r_gap_cnt == c_GAP_W'(GAP - 1)) w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the state being entered so they appear registered in that state.
   // The SOF word captures the packet id at the handshake edge, so no separate id latch is kept.
   always_comb begin
      w_packet = '0;
      w_valid  = 1'b0;
      w_ready  = 1'b0;
      w_shift  = 1'b0;
      case (w_next_state)
         ST_IDLE:  w_ready = 1'b1;
         ST_SOF: begin
            w_packet = {SOF, r_pkt_count};
            w_valid  = 1'b1;
         end
         ST_HDR: begin
            w_packet = {DTYPE, 32'(DLEN), PHL_ID};
            w_valid  = 1'b1;
         end
         ST_DATA: begin
            w_packet = {w_word[c_HALF_W-1:0], w_word[c_WORD_W-1:c_HALF_W]};
            w_valid  = 1'b1;
            w_shift  = 1'b1;
         end
         ST_TRAIL: w_valid = 1'b1;
         default:  w_packet = '0;
      endcase
   end

   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         r_packet <= '0;
         r_valid  <= 1'b0;
         r_ready  <= 1'b0;
      end else begin
         r_packet <= w_packet;
         r_valid  <= w_valid;
         r_ready  <= w_ready;
      end
   end

   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         r_gap_cnt <= '0;
      end else if (r_state != ST_GAP) begin
         r_gap_cnt <= '0;
      end else begin
         r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
      end
   end

   always_ff @(posedge tx_pixel_clk) begin
      if (!rst_n) begin
         r_pkt_count <= '0;
      end else if (r_state == ST_DATA && w_next_state == ST_TRAIL) begin
         r_pkt_count <= r_pkt_count + 24'd1;
      end
   end

   assign packet           = r_packet;
   assign my_mipi_tx_VALID = r_valid;
   assign data_ready       = r_ready;
   assign pkt_count        = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_mipi_packet_tx.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_mipi_packet_tx: directed and random checks of the packetizer   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_mipi_packet_tx;

   localparam int NW  = 3;
   localparam int PER = NW + 4 + 17;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [47:0]   d6;
   logic          dv6;
   logic          dr6;
   logic [47:0]   pk6;
   logic          vl6;
   logic [23:0]   pc6;
   logic [143:0]  d18;
   logic          dv18;
   logic          dr18;
   logic [47:0]   pk18;
   logic          vl18;
   logic [23:0]   pc18;

   mipi_packet_tx #(.DLEN(6)) dut6 (
      .tx_pixel_clk (clk), .rst_n (rst_n), .data (d6), .data_valid (dv6),
      .data_ready (dr6), .packet (pk6), .my_mipi_tx_VALID (vl6), .pkt_count (pc6)
   );

   mipi_packet_tx #(.DLEN(18)) dut18 (
      .tx_pixel_clk (clk), .rst_n (rst_n), .data (d18), .data_valid (dv18),
      .data_ready (dr18), .packet (pk18), .my_mipi_tx_VALID (vl18), .pkt_count (pc18)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [143:0] obs, input logic [143:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Scoreboard of accepted payloads and the id each should carry
   logic [143:0] sb_pay[$];
   logic [23:0]  sb_id[$];
   logic [47:0]  frame[$];
   logic [143:0] mon_pay;
   logic [23:0]  model_cnt;
   logic [47:0]  got[3];
   logic [159:0] rnd;
   int           frames_done;
   int           cyc = 0;
   int           last_sof;
   bit           mon_en;
   bit           b2b;

   always @(posedge clk) cyc <= cyc + 1;

   // Receiver-like decoder of the DLEN=18 stream
   always @(negedge clk) begin
      if (mon_en) begin
         if (vl18) begin
            if (frame.size() == 0) begin
               if (last_sof >= 0) begin
                  check_eq("sof_spacing_ok", 144'((cyc - last_sof) >= PER), 144'd1);
                  if (b2b) check_eq("b2b_period", 144'(cyc - last_sof), 144'(PER));
               end
               last_sof = cyc;
            end
            frame.push_back(pk18);
         end else begin
            check_eq("idle_word_zero", 144'(pk18), 144'd0);
            if (frame.size() != 0) begin
               check_eq("frame_len", 144'(frame.size()), 144'(NW + 3));
               check_eq("frame_was_accepted", 144'(sb_id.size() != 0), 144'd1);
               if (sb_id.size() != 0 && frame.size() == NW + 3) begin
                  mon_pay = '0;
                  for (int i = 0; i < NW; i++)
                     mon_pay = {mon_pay[95:0], frame[2+i][23:0], frame[2+i][47:24]};
                  check_eq("sof_word", 144'(frame[0]), 144'({24'hEAFF99, sb_id[0]}));
                  check_eq("hdr_word", 144'(frame[1]), 144'({8'h01, 32'd18, 8'h00}));
                  check_eq("payload", mon_pay, sb_pay[0]);
                  check_eq("trailer", 144'(frame[NW+2]), 144'd0);
                  model_cnt = model_cnt + 24'd1;
                  check_eq("pkt_count", 144'(pc18), 144'(model_cnt));
                  void'(sb_id.pop_front());
                  void'(sb_pay.pop_front());
                  frames_done++;
               end
               frame.delete();
            end
         end
      end
   end

   task automatic drive18(input int max_hs, input int max_cyc, input bit random_valid);
      int hs;
      hs = 0;
      for (int i = 0; i < max_cyc && hs < max_hs; i++) begin
         @(negedge clk);
         dv18 = random_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         rnd  = {$urandom, $urandom, $urandom, $urandom, $urandom};
         d18  = rnd[143:0];
         if (dv18 && dr18) begin
            sb_pay.push_back(d18);
            sb_id.push_back(model_cnt);
            hs++;
         end
      end
      @(negedge clk);
      dv18 = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && (sb_id.size() != 0 || frame.size() != 0); k++) @(negedge clk);
      check_eq("drain_empty", 144'(sb_id.size() + frame.size()), 144'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_cnt = '0;
      @(negedge clk);
   endtask

   // Directed single packet on the DLEN=18 instance with cycle-exact schedule checks
   task automatic expect_packet18(input logic [143:0] p, input logic [23:0] id);
      logic [47:0] c;
      for (int k = 0; k < 100 && !dr18; k++) @(negedge clk);
      check_eq("ready_before_send", 144'(dr18), 144'd1);
      d18  = p;
      dv18 = 1'b1;
      @(negedge clk);
      dv18 = 1'b0;
      d18  = ~p;
      check_eq("sof18", 144'({vl18, pk18}), 144'({1'b1, 24'hEAFF99, id}));
      @(negedge clk);
      check_eq("hdr18", 144'({vl18, pk18}), 144'({1'b1, 8'h01, 32'h12, 8'h00}));
      for (int i = 0; i < NW; i++) begin
         @(negedge clk);
         c = p[143-48*i -: 48];
         check_eq("data18", 144'({vl18, pk18}), 144'({1'b1, c[23:0], c[47:24]}));
         got[i] = pk18;
      end
      @(negedge clk);
      check_eq("trail18", 144'({vl18, dr18, pk18}), 144'({1'b1, 1'b0, 48'h0}));
      for (int g = 0; g < 17; g++) begin
         @(negedge clk);
         check_eq("gap18", 144'({vl18, dr18, pk18}), 144'd0);
      end
      @(negedge clk);
      check_eq("ready_after_gap18", 144'(dr18), 144'd1);
      check_eq("count_after18", 144'(pc18), 144'(24'(id + 24'd1)));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [143:0] mw;
      rst_n = 1'b0; dv6 = 1'b0; dv18 = 1'b0; d6 = '0; d18 = '0;
      mon_en = 1'b0; b2b = 1'b0; last_sof = -1; model_cnt = '0; frames_done = 0;
      repeat (3) @(negedge clk);
      check_eq("rst_outputs6", 144'({vl6, dr6, pk6}), 144'd0);
      check_eq("rst_count6", 144'(pc6), 144'd0);
      check_eq("rst_outputs18", 144'({vl18, dr18, pk18, pc18}), 144'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_rst", 144'({dr6, dr18}), 144'(2'b11));

      // Single packet, DLEN=6
      d6 = 48'h112233445566;
      dv6 = 1'b1;
      @(negedge clk);
      dv6 = 1'b0;
      d6 = '1;
      check_eq("sof6", 144'({vl6, pk6}), 144'({1'b1, 48'hEAFF99_000000}));
      @(negedge clk);
      check_eq("hdr6", 144'({vl6, pk6}), 144'({1'b1, 48'h01_00000006_00}));
      @(negedge clk);
      check_eq("data6", 144'({vl6, pk6}), 144'({1'b1, 48'h445566_112233}));
      @(negedge clk);
      check_eq("trail6", 144'({vl6, pk6}), 144'({1'b1, 48'h0}));
      check_eq("count6", 144'(pc6), 144'd1);
      for (int g = 0; g < 17; g++) begin
         @(negedge clk);
         check_eq("gap6", 144'({vl6, dr6, pk6}), 144'd0);
      end
      @(negedge clk);
      check_eq("ready_after_gap6", 144'(dr6), 144'd1);

      // Reset during the second data word, then restart with the same id
      mw = 144'hA0A1A2A3A4A5_B0B1B2B3B4B5_C0C1C2C3C4C5;
      d18 = mw;
      dv18 = 1'b1;
      @(negedge clk);
      dv18 = 1'b0;
      check_eq("rstmid_sof", 144'(pk18), 144'(48'hEAFF99_000000));
      repeat (3) @(negedge clk);
      check_eq("rstmid_d1", 144'(pk18), 144'(48'hB3B4B5_B0B1B2));
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rstmid_out", 144'({vl18, dr18, pk18}), 144'd0);
      check_eq("rstmid_count", 144'(pc18), 144'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("rstmid_ready", 144'(dr18), 144'd1);
      expect_packet18(mw, 24'd0);
      check_eq("mw_word0", 144'(got[0]), 144'(48'hA3A4A5_A0A1A2));
      check_eq("mw_word1", 144'(got[1]), 144'(48'hB3B4B5_B0B1B2));
      check_eq("mw_word2", 144'(got[2]), 144'(48'hC3C4C5_C0C1C2));

      // Loopback: 20 back-to-back random payloads, ids 0..19
      do_reset();
      frames_done = 0;
      last_sof = -1;
      b2b = 1'b1;
      mon_en = 1'b1;
      drive18(20, 2000, 1'b0);
      drain();
      check_eq("loop_frames", 144'(frames_done), 144'd20);
      check_eq("loop_count", 144'(pc18), 144'd20);

      // Random data_valid toggling
      b2b = 1'b0;
      last_sof = -1;
      drive18(1000, 400, 1'b1);
      drain();
      check_eq("rand_count", 144'(pc18), 144'(model_cnt));
      mon_en = 1'b0;

      // Id wrap
      for (int k = 0; k < 100 && !dr18; k++) @(negedge clk);
      force dut18.r_pkt_count = 24'hFFFFFF;
      @(negedge clk);
      release dut18.r_pkt_count;
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom};
      expect_packet18(rnd[143:0], 24'hFFFFFF);
      check_eq("wrap_count", 144'(pc18), 144'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
